// File: rtl/camera_pixel_capture_pkg.sv
// Shared types and defaults for the camera capture front end and its pixel consumers.
package camera_pixel_capture_pkg;

  localparam int IMG_WIDTH_DEF  = 320;
  localparam int IMG_HEIGHT_DEF = 240;

  // {R[3:0], G[3:0], B[3:0]}, the same word blurring_filter consumes
  typedef logic [11:0] pixel_t;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_ACTIVE = 2'd2
  } cap_state_e;

endpackage

// File: rtl/camera_pixel_capture_edge_detect.sv
// Registered rise/fall pulse generator for a vector of synchronous level inputs.
module camera_pixel_capture_edge_detect
  import camera_pixel_capture_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] sig_in,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] prev_q, prev_d;
  logic [W-1:0] rise_q, rise_d;
  logic [W-1:0] fall_q, fall_d;

  always_comb begin
    prev_d = sig_in;
    rise_d = sig_in & ~prev_q;
    fall_d = ~sig_in & prev_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/camera_pixel_capture.sv
// Camera byte-stream to RGB444 pixel capture with frame geometry tracking and error flagging.
module camera_pixel_capture
  import camera_pixel_capture_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic        cam_byte_valid,
  input  logic [7:0]  cam_data,
  output logic        ready_out,
  output logic [11:0] data_out,
  output logic [8:0]  x_count,
  output logic [7:0]  y_count,
  output logic        frame_start,
  output logic        frame_done,
  output logic        line_err
);

  localparam logic [9:0] W_LIM  = 10'(IMG_WIDTH);
  localparam logic [8:0] H_LIM  = 9'(IMG_HEIGHT);
  localparam logic [8:0] H_LAST = 9'(IMG_HEIGHT - 1);

  cap_state_e state_q, state_d;
  logic [9:0] col_q, col_d;
  logic [8:0] row_q, row_d;
  logic       phase_q, phase_d;
  logic [3:0] red_q, red_d;
  pixel_t     data_q, data_d;
  logic [8:0] xo_q, xo_d;
  logic [7:0] yo_q, yo_d;
  logic       rdy_q, rdy_d;
  logic       fs_q, fs_d;
  logic       fd_q, fd_d;
  logic       err_q, err_d;

  logic [1:0] rise, fall;
  logic [1:0] unused_rise;
  logic       vsync_fall, href_fall;

  camera_pixel_capture_edge_detect #(.W(2)) u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .sig_in  ({cam_href, cam_vsync}),
    .rise    (rise),
    .fall    (fall)
  );

  assign unused_rise = rise;
  assign vsync_fall  = fall[0];
  assign href_fall   = fall[1];

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    phase_d = phase_q;
    red_d   = red_q;
    data_d  = data_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    rdy_d   = 1'b0;
    fs_d    = 1'b0;
    fd_d    = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      ST_SYNC: begin
        if (cam_vsync) state_d = ST_VBLANK;
      end
      ST_VBLANK: begin
        // vsync must actually fall, so a frame that just completed waits for the next blanking
        if (vsync_fall && !cam_vsync) begin
          state_d = ST_ACTIVE;
          col_d   = '0;
          row_d   = '0;
          phase_d = 1'b0;
          xo_d    = '0;
          yo_d    = '0;
          err_d   = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (cam_vsync) begin
          state_d = ST_VBLANK;
          phase_d = 1'b0;
          err_d   = 1'b1;
        end else begin
          if (cam_href && cam_byte_valid) begin
            if (row_q >= H_LIM) begin
              err_d = 1'b1;
            end else if (!phase_q) begin
              red_d   = cam_data[3:0];
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (col_q >= W_LIM) begin
                err_d = 1'b1;
              end else begin
                rdy_d  = 1'b1;
                data_d = {red_q, cam_data};
                xo_d   = col_q[8:0];
                yo_d   = row_q[7:0];
                fs_d   = (col_q == 10'd0) && (row_q == 9'd0);
                col_d  = col_q + 10'd1;
              end
            end
          end
          // line end is evaluated after any byte taken this cycle
          if (href_fall) begin
            if (col_d != W_LIM || phase_d) err_d = 1'b1;
            col_d   = '0;
            phase_d = 1'b0;
            row_d   = row_q + 9'd1;
            if (row_q == H_LAST) begin
              fd_d    = 1'b1;
              state_d = ST_VBLANK;
            end
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_SYNC;
      col_q   <= '0;
      row_q   <= '0;
      phase_q <= 1'b0;
      red_q   <= '0;
      data_q  <= '0;
      xo_q    <= '0;
      yo_q    <= '0;
      rdy_q   <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      phase_q <= phase_d;
      red_q   <= red_d;
      data_q  <= data_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      rdy_q   <= rdy_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  assign ready_out   = rdy_q;
  assign data_out    = data_q;
  assign x_count     = xo_q;
  assign y_count     = yo_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign line_err    = err_q;

endmodule

// File: tb/tb_camera_pixel_capture.sv
// Directed bench for camera_pixel_capture on a reduced 8x12 frame with a pixel scoreboard.
module tb_camera_pixel_capture;

  localparam int W = 8;
  localparam int H = 12;

  logic        clk;
  logic        reset_n;
  logic        cam_vsync;
  logic        cam_href;
  logic        cam_byte_valid;
  logic [7:0]  cam_data;
  logic        ready_out;
  logic [11:0] data_out;
  logic [8:0]  x_count;
  logic [7:0]  y_count;
  logic        frame_start;
  logic        frame_done;
  logic        line_err;

  typedef struct packed {
    logic [11:0] d;
    logic [8:0]  x;
    logic [7:0]  y;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   n_fs  = 0;
  int   n_fd  = 0;
  int   n_rdy = 0;

  camera_pixel_capture #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cam_vsync      (cam_vsync),
    .cam_href       (cam_href),
    .cam_byte_valid (cam_byte_valid),
    .cam_data       (cam_data),
    .ready_out      (ready_out),
    .data_out       (data_out),
    .x_count        (x_count),
    .y_count        (y_count),
    .frame_start    (frame_start),
    .frame_done     (frame_done),
    .line_err       (line_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // output monitor: pops the scoreboard on every pixel strobe
  always @(negedge clk) begin
    if (reset_n) begin
      if (ready_out) begin
        n_rdy++;
        if (sb.size() == 0) begin
          chk("rdy_unexpected", 32'(ready_out), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("data_out", 32'(data_out), 32'(e.d));
          chk("x_count", 32'(x_count), 32'(e.x));
          chk("y_count", 32'(y_count), 32'(e.y));
        end
      end
      if (frame_start) begin
        n_fs++;
        chk("fs_at_origin", 32'({ready_out, x_count, y_count}), 32'({1'b1, 17'd0}));
      end
      if (frame_done) n_fd++;
    end
  end

  // one camera line; pixel p of line y uses a pattern unless fixed=1 (0x0A,0xBC)
  task automatic send_line(input int y, input int nbytes, input int p0,
                           input bit fixed, input bit expect_out);
    logic [3:0] r;
    logic [7:0] gb;
    exp_t e;
    for (int i = 0; i < nbytes; i++) begin
      int p;
      p = p0 + i / 2;
      if (fixed) begin r = 4'hA; gb = 8'hBC; end
      else begin r = 4'(p * 3 + y); gb = 8'(p * 17 + y * 5 + 1); end
      @(negedge clk);
      cam_href = 1'b1;
      cam_byte_valid = 1'b1;
      if (i % 2 == 0) begin
        cam_data = fixed ? 8'h0A : {4'($urandom_range(0, 15)), r};
      end else begin
        cam_data = gb;
        if (expect_out && p < W && y < H) begin
          e.d = {r, gb}; e.x = 9'(p); e.y = 8'(y);
          sb.push_back(e);
        end
        if (p % 2 == 1) begin
          @(negedge clk);
          cam_byte_valid = 1'b0;
          cam_data = 8'hFF;
        end
      end
    end
    @(negedge clk);
    cam_href = 1'b0;
    cam_byte_valid = 1'b0;
    cam_data = 8'h00;
    repeat (4) @(negedge clk);
  endtask

  task automatic start_frame();
    @(negedge clk);
    cam_vsync = 1'b1;
    repeat (3) @(negedge clk);
    cam_vsync = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int fs0, fd0, rdy0;
    exp_t e;
    reset_n = 1'b0;
    cam_vsync = 1'b0;
    cam_href = 1'b0;
    cam_byte_valid = 1'b0;
    cam_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_x", 32'(x_count), 32'd0);
    chk("rst_y", 32'(y_count), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(line_err), 32'd0);
    reset_n = 1'b1;

    // bytes before any vsync are ignored
    send_line(0, 2 * W, 0, 1'b0, 1'b0);
    chk("sync_ignore", 32'(n_rdy), 32'd0);

    // clean frame, constant pixel
    fs0 = n_fs; fd0 = n_fd; rdy0 = n_rdy;
    start_frame();
    for (int y = 0; y < H; y++) send_line(y, 2 * W, 0, 1'b1, 1'b1);
    chk("A_pixels", 32'(n_rdy - rdy0), 32'(W * H));
    chk("A_fs", 32'(n_fs - fs0), 32'd1);
    chk("A_fd", 32'(n_fd - fd0), 32'd1);
    chk("A_err", 32'(line_err), 32'd0);
    chk("A_sb_empty", 32'(sb.size()), 32'd0);

    // first pixel latency, then an over-long line 5
    fs0 = n_fs; fd0 = n_fd;
    start_frame();
    @(negedge clk);
    cam_href = 1'b1; cam_byte_valid = 1'b1; cam_data = 8'h05;
    @(negedge clk);
    cam_data = 8'h3C;
    e.d = 12'h53C; e.x = 9'd0; e.y = 8'd0;
    sb.push_back(e);
    chk("lat_pre", 32'(ready_out), 32'd0);
    @(negedge clk);
    cam_byte_valid = 1'b0;
    chk("lat_rdy", 32'(ready_out), 32'd1);
    chk("lat_fs", 32'(frame_start), 32'd1);
    @(negedge clk);
    chk("lat_pulse_end", 32'(ready_out), 32'd0);
    chk("lat_hold", 32'(data_out), 32'h53C);
    send_line(0, 2 * W - 2, 1, 1'b0, 1'b1);
    for (int y = 1; y < H; y++) begin
      send_line(y, (y == 5) ? 2 * W + 2 : 2 * W, 0, 1'b0, 1'b1);
      if (y == 4) chk("C_err_before", 32'(line_err), 32'd0);
      if (y == 5) chk("C_err_long", 32'(line_err), 32'd1);
    end
    chk("C_fd", 32'(n_fd - fd0), 32'd1);
    chk("C_err_sticky", 32'(line_err), 32'd1);
    chk("C_sb_empty", 32'(sb.size()), 32'd0);

    // odd byte count on line 10
    fd0 = n_fd;
    start_frame();
    chk("D_err_cleared", 32'(line_err), 32'd0);
    for (int y = 0; y < H; y++) begin
      send_line(y, (y == 10) ? 2 * W + 1 : 2 * W, 0, 1'b0, 1'b1);
      if (y == 9) chk("D_err_before", 32'(line_err), 32'd0);
      if (y == 10) chk("D_err_odd", 32'(line_err), 32'd1);
    end
    chk("D_fd", 32'(n_fd - fd0), 32'd1);
    chk("D_err_end", 32'(line_err), 32'd1);

    // vsync aborts after line 7, next frame clean
    fd0 = n_fd;
    start_frame();
    for (int y = 0; y < 8; y++) send_line(y, 2 * W, 0, 1'b0, 1'b1);
    @(negedge clk);
    cam_vsync = 1'b1;
    repeat (3) @(negedge clk);
    chk("E_abort_err", 32'(line_err), 32'd1);
    chk("E_no_fd", 32'(n_fd - fd0), 32'd0);
    cam_vsync = 1'b0;
    repeat (4) @(negedge clk);
    chk("F_err_cleared", 32'(line_err), 32'd0);
    for (int y = 0; y < H; y++) send_line(y, 2 * W, 0, 1'b0, 1'b1);
    chk("F_fd", 32'(n_fd - fd0), 32'd1);
    chk("F_err", 32'(line_err), 32'd0);

    // reset in the middle of line 3
    start_frame();
    for (int y = 0; y < 3; y++) send_line(y, 2 * W, 0, 1'b0, 1'b1);
    @(negedge clk);
    cam_href = 1'b1; cam_byte_valid = 1'b1; cam_data = 8'h01;
    @(negedge clk);
    cam_data = 8'h23;
    e.d = 12'h123; e.x = 9'd0; e.y = 8'd3;
    sb.push_back(e);
    @(negedge clk);
    cam_byte_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready_out), 32'd0);
    chk("mid_rst_data", 32'(data_out), 32'd0);
    chk("mid_rst_xy", 32'({x_count, y_count}), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cam_href = 1'b0;
    rdy0 = n_rdy; fs0 = n_fs; fd0 = n_fd;
    for (int y = 3; y < 6; y++) send_line(y, 2 * W, 0, 1'b0, 1'b0);
    chk("G_ignored", 32'(n_rdy - rdy0), 32'd0);
    start_frame();
    for (int y = 0; y < H; y++) send_line(y, 2 * W, 0, 1'b0, 1'b1);
    chk("G_fs", 32'(n_fs - fs0), 32'd1);
    chk("G_fd", 32'(n_fd - fd0), 32'd1);
    chk("G_pixels", 32'(n_rdy - rdy0), 32'(W * H));
    chk("G_err", 32'(line_err), 32'd0);
    chk("G_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
